ram16k_arbiter: RTL and testbench
=================================

Name: ram16k_arbiter

Overview:
- Shares one ram16k (14-bit address, 16-bit data, combinational read, write on clk edge when load=1) between two requesters, e.g. CPU data port (r0) and a DMA/screen-refresh engine (r1).
- Per-requester req/ack handshake; round-robin arbitration; drives the RAM's address/in/load pins and returns read data.
- Sits between the requesters and the RAM instance.

Parameters:
- ADDR_W, 14, RAM address width.
- DATA_W, 16, RAM data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- r0_req  in  1  requester 0 transaction request.
- r0_we  in  1  1 = write, 0 = read.
- r0_addr  in  ADDR_W  requester 0 address.
- r0_wdata  in  DATA_W  requester 0 write data.
- r0_ack  out  1  one-cycle completion pulse.
- r0_rdata  out  DATA_W  read data, valid while r0_ack=1.
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata: same as r0_*, for requester 1.
- ram_address  out  ADDR_W  to RAM address.
- ram_in  out  DATA_W  to RAM in.
- ram_load  out  1  to RAM load.
- ram_out  in  DATA_W  from RAM out.

Behaviour:
- Clock and reset: one clock, clk; synchronous active-low reset rst_n, sampled only on the rising edge of clk.
- Reset values: state IDLE, rr pointer = r0 preferred, owner = r0, latched addr/wdata/we = 0, ram_address = 0, ram_in = 0, ram_load = 0, both ack = 0, both rdata = 0.
- FSM: IDLE -> ACCESS -> RESP -> IDLE, one transaction per 3 cycles.
  - IDLE: if any req is high at the edge, select a winner, latch its addr/wdata/we and the owner, go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: ram_address = latched addr, ram_in = latched wdata. ram_load = latched we AND rst_n (combinational gate, so a reset asserted in the ACCESS cycle suppresses the write). At the edge, capture ram_out into the owner's rdata register, then go to RESP.
  - RESP: owner's ack = 1 for exactly this cycle; owner's rdata is valid. The other requester's ack = 0. No req sampling. Next state is IDLE.
- Latency: req high at edge k (state IDLE) -> ACCESS during cycle k+1 -> ack during cycle k+2.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees ack.
  - req still high in the IDLE cycle after ack is a new transaction.
  - Dropping req before ack is illegal; the arbiter completes the latched transaction regardless.
- Arbitration:
  - If only one req is high, it wins.
  - If both are high, the requester not granted last wins; the pointer updates on each grant. After reset, r0 wins the first tie.
  - Neither requester can be starved: maximum wait is one transaction.
- Outputs outside ACCESS: ram_load = 0; ram_address and ram_in hold their last latched values.
- rdata: each rdata register holds its value until that requester's next read completes. A write does not update rdata (rdata is left unchanged).
- Reset mid-operation: any state -> IDLE next edge; no ack is issued for the aborted transaction; RAM contents are unaffected except by writes completed before the reset cycle.

Optional Feature:
- Macro: RAM16K_ARB_GRANT_CNT_EN.
- Defined: adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each).
  - Each counter increments on entry to RESP for its owner and saturates at 16'hFFFF.
  - Both reset to 0.
- Undefined: these ports and the counter logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package ram_arb_pkg:
  - State encoding constants ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2.
  - Default widths ADDR_W = 14, DATA_W = 16.
- Sub-module rr_arbiter2: inputs req0, req1 and an update strobe; outputs a one-hot grant. Holds the last-grant pointer internally.

Test Plan:
- Single write then read: r0 writes 16'h3A5C to 14'h0003 -> ram_load=1 only in the ACCESS cycle, r0_ack two cycles after req is sampled; then r0 reads 14'h0003 -> r0_rdata = 16'h3A5C while r0_ack=1.
- Simultaneous requests after reset: r0 writes 16'h1111 to 14'h3FFF, r1 writes 16'h2222 to 14'h3FFF, both in the same cycle -> r0 served first, then r1; a read of 14'h3FFF returns 16'h2222.
- Continuous contention: both req held high for 6 transactions -> grant order r0, r1, r0, r1, r0, r1; each ack is a single-cycle pulse.
- Read does not disturb memory: r1 reads 14'h0007 after r0 wrote 16'h00FF there -> r1_rdata = 16'h00FF, ram_load = 0 throughout, r0_rdata unchanged.
- Reset in ACCESS: rst_n=0 during the ACCESS cycle of a write of 16'hBEEF to 14'h0000 -> ram_load = 0 that cycle, no ack; a later read of 14'h0000 returns the prior value.
- With RAM16K_ARB_GRANT_CNT_EN defined: 3 r0 and 2 r1 transactions -> gnt_cnt0 = 3, gnt_cnt1 = 2; after reset both = 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the ram16k arbiter: state encoding and default widths.
package ram_arb_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; grant_c is one-hot (bit 0 = requester 0).
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       update,
  output logic [1:0] grant_c
);

  // Set when requester 1 should win the next tie, i.e. requester 0 was granted last
  logic prefer1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prefer1_q <= 1'b0;
    end else if (update && (req0 || req1)) begin
      prefer1_q <= grant_c[0];
    end
  end

  always_comb begin
    grant_c = 2'b00;
    if (req0 && req1) begin
      grant_c = prefer1_q ? 2'b10 : 2'b01;
    end else if (req0) begin
      grant_c = 2'b01;
    end else if (req1) begin
      grant_c = 2'b10;
    end
  end

endmodule

// File: rtl/ram16k_arbiter.sv
// Shares one ram16k between two req/ack requesters, one transaction per three cycles.
// Define RAM16K_ARB_GRANT_CNT_EN to add saturating per-requester grant counters.
module ram16k_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
`ifdef RAM16K_ARB_GRANT_CNT_EN
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1,
`endif
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                r0_ack_d, r1_ack_d;
  logic [DATA_W-1:0]   r0_rdata_d, r1_rdata_d;
  logic [1:0]          grant_c;
  logic                update_c;
`ifdef RAM16K_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0]    gnt_cnt0_d, gnt_cnt1_d;
`endif

  assign update_c = (state_q == ST_IDLE);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (r0_req),
    .req1    (r1_req),
    .update  (update_c),
    .grant_c (grant_c)
  );

  // Address/data come straight from the latched transaction so they hold outside ACCESS
  assign ram_address = addr_q;
  assign ram_in      = wdata_q;
  // Gated with rst_n so a reset landing in the ACCESS cycle cancels the write
  assign ram_load    = (state_q == ST_ACCESS) && we_q && rst_n;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    r0_ack_d   = 1'b0;
    r1_ack_d   = 1'b0;
    r0_rdata_d = r0_rdata;
    r1_rdata_d = r1_rdata;
`ifdef RAM16K_ARB_GRANT_CNT_EN
    gnt_cnt0_d = gnt_cnt0;
    gnt_cnt1_d = gnt_cnt1;
`endif
    case (state_q)
      ST_IDLE: begin
        if (r0_req || r1_req) begin
          owner_d = grant_c[1];
          we_d    = grant_c[1] ? r1_we    : r0_we;
          addr_d  = grant_c[1] ? r1_addr  : r0_addr;
          wdata_d = grant_c[1] ? r1_wdata : r0_wdata;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (owner_q) begin
          r1_ack_d = 1'b1;
          if (!we_q) r1_rdata_d = ram_out;
`ifdef RAM16K_ARB_GRANT_CNT_EN
          if (gnt_cnt1 != '1) gnt_cnt1_d = gnt_cnt1 + CNT_W'(1);
`endif
        end else begin
          r0_ack_d = 1'b1;
          if (!we_q) r0_rdata_d = ram_out;
`ifdef RAM16K_ARB_GRANT_CNT_EN
          if (gnt_cnt0 != '1) gnt_cnt0_d = gnt_cnt0 + CNT_W'(1);
`endif
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
`ifdef RAM16K_ARB_GRANT_CNT_EN
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      r0_ack   <= r0_ack_d;
      r1_ack   <= r1_ack_d;
      r0_rdata <= r0_rdata_d;
      r1_rdata <= r1_rdata_d;
`ifdef RAM16K_ARB_GRANT_CNT_EN
      gnt_cnt0 <= gnt_cnt0_d;
      gnt_cnt1 <= gnt_cnt1_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Bench for ram16k_arbiter: vector table, hand-written corner sequences and a
// randomized two-requester run checked against a transaction-level model.
`timescale 1ns/1ps
module tb_ram16k_arbiter;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_ack, r1_ack;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_in, ram_out;
  logic          ram_load;
`ifdef RAM16K_ARB_GRANT_CNT_EN
  logic [15:0]   gnt_cnt0, gnt_cnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_rd [2];

  always #5 clk = ~clk;

  ram16k_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .r0_req      (r0_req),
    .r0_we       (r0_we),
    .r0_addr     (r0_addr),
    .r0_wdata    (r0_wdata),
    .r0_ack      (r0_ack),
    .r0_rdata    (r0_rdata),
    .r1_req      (r1_req),
    .r1_we       (r1_we),
    .r1_addr     (r1_addr),
    .r1_wdata    (r1_wdata),
    .r1_ack      (r1_ack),
    .r1_rdata    (r1_rdata),
`ifdef RAM16K_ARB_GRANT_CNT_EN
    .gnt_cnt0    (gnt_cnt0),
    .gnt_cnt1    (gnt_cnt1),
`endif
    .ram_address (ram_address),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_out     (ram_out)
  );

  // The shared ram16k: combinational read, write on the clock edge
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign ram_out = mem[ram_address];
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (id == 0) begin
      r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
    end else begin
      r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
    end
  endtask

  task automatic chk_rdata(input string nm);
    chk({nm, " r0_rdata"}, 32'(r0_rdata), 32'(exp_rd[0]));
    chk({nm, " r1_rdata"}, 32'(r1_rdata), 32'(exp_rd[1]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    chk("reset acks", 32'({r1_ack, r0_ack}), 32'd0);
    chk("reset load", 32'(ram_load), 32'd0);
    chk("reset addr", 32'(ram_address), 32'd0);
    chk("reset ram_in", 32'(ram_in), 32'd0);
    chk_rdata("reset");
    rst_n = 1'b1;
  endtask

  // Single isolated transaction from the IDLE cycle: ACCESS next cycle, ack the one after
  task automatic do_txn(input int id, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                        input string nm);
    drive(id, 1'b1, we, addr, wdata);
    chk({nm, " load idle"}, 32'(ram_load), 32'd0);
    tick();
    chk({nm, " ack early"}, 32'({r1_ack, r0_ack}), 32'd0);
    chk({nm, " load access"}, 32'(ram_load), 32'(we));
    chk({nm, " addr"}, 32'(ram_address), 32'(addr));
    chk({nm, " ram_in"}, 32'(ram_in), 32'(wdata));
    tick();
    chk({nm, " ack"}, 32'({r1_ack, r0_ack}), (id == 0) ? 32'd1 : 32'd2);
    chk({nm, " load resp"}, 32'(ram_load), 32'd0);
    if (!we) exp_rd[id] = exp_rdata;
    chk_rdata(nm);
    drive(id, 1'b0, we, addr, wdata);
    tick();
    chk({nm, " ack pulse"}, 32'({r1_ack, r0_ack}), 32'd0);
    chk({nm, " addr hold"}, 32'(ram_address), 32'(addr));
  endtask

  typedef struct {
    int            id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t vecs [6];

  // Randomized-phase model state
  logic [DW-1:0] model_mem [16];
  logic          pend  [2];
  logic          p_we  [2];
  int            p_idx [2];
  logic [DW-1:0] p_wd  [2];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            skip, cur, last_win;
    logic [DW-1:0] cur_rd;
    logic [31:0]   e_ack;
    logic          e_load;

    vecs[0] = '{0, 1'b1, 14'h0003, 16'h3A5C, 16'h0000};
    vecs[1] = '{0, 1'b0, 14'h0003, 16'h0000, 16'h3A5C};
    vecs[2] = '{0, 1'b1, 14'h0007, 16'h00FF, 16'h0000};
    vecs[3] = '{1, 1'b0, 14'h0007, 16'h0000, 16'h00FF};
    vecs[4] = '{1, 1'b1, 14'h0000, 16'h1234, 16'h0000};
    vecs[5] = '{0, 1'b0, 14'h0000, 16'h0000, 16'h1234};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      do_txn(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
             $sformatf("vec%0d", i));
    end

    // Simultaneous writes after reset: r0 first, r1 second, r1's data survives
    do_reset();
    drive(0, 1'b1, 1'b1, 14'h3FFF, 16'h1111);
    drive(1, 1'b1, 1'b1, 14'h3FFF, 16'h2222);
    tick();
    chk("sim first ram_in", 32'(ram_in), 32'h1111);
    chk("sim first load", 32'(ram_load), 32'd1);
    tick();
    chk("sim first ack", 32'({r1_ack, r0_ack}), 32'd1);
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    chk("sim gap ack", 32'({r1_ack, r0_ack}), 32'd0);
    chk("sim gap load", 32'(ram_load), 32'd0);
    tick();
    chk("sim second ram_in", 32'(ram_in), 32'h2222);
    chk("sim second load", 32'(ram_load), 32'd1);
    tick();
    chk("sim second ack", 32'({r1_ack, r0_ack}), 32'd2);
    drive(1, 1'b0, 1'b0, '0, '0);
    tick();
    do_txn(0, 1'b0, 14'h3FFF, 16'h0000, 16'h2222, "sim readback");

    // Continuous contention: both held high, six alternating grants
    do_reset();
    drive(0, 1'b1, 1'b0, 14'h0003, 16'h0000);
    drive(1, 1'b1, 1'b0, 14'h0007, 16'h0000);
    for (int c = 1; c <= 18; c++) begin
      tick();
      e_ack = 32'd0;
      if (c % 3 == 2) begin
        if (((c - 2) / 3) % 2 == 0) begin
          e_ack = 32'd1;
          exp_rd[0] = 16'h3A5C;
        end else begin
          e_ack = 32'd2;
          exp_rd[1] = 16'h00FF;
        end
      end
      chk($sformatf("contend c%0d ack", c), 32'({r1_ack, r0_ack}), e_ack);
      chk($sformatf("contend c%0d load", c), 32'(ram_load), 32'd0);
      chk_rdata($sformatf("contend c%0d", c));
      if (c == 17) begin
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
      end
    end

    // Reset during the ACCESS cycle of a write aborts it
    drive(0, 1'b1, 1'b1, 14'h0000, 16'hBEEF);
    tick();
    chk("abort load before rst", 32'(ram_load), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort load gated", 32'(ram_load), 32'd0);
    tick();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    chk("abort ack in rst", 32'({r1_ack, r0_ack}), 32'd0);
    rst_n = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    chk("abort no ack 1", 32'({r1_ack, r0_ack}), 32'd0);
    tick();
    chk("abort no ack 2", 32'({r1_ack, r0_ack}), 32'd0);
    do_txn(0, 1'b0, 14'h0000, 16'h0000, 16'h1234, "abort readback");

`ifdef RAM16K_ARB_GRANT_CNT_EN
    do_reset();
    chk("cnt0 reset", 32'(gnt_cnt0), 32'd0);
    chk("cnt1 reset", 32'(gnt_cnt1), 32'd0);
    for (int i = 0; i < 3; i++) do_txn(0, 1'b1, 14'(14'h0200 + i), 16'(i), 16'h0, "cnt r0");
    for (int i = 0; i < 2; i++) do_txn(1, 1'b1, 14'(14'h0210 + i), 16'(i), 16'h0, "cnt r1");
    chk("cnt0 after", 32'(gnt_cnt0), 32'd3);
    chk("cnt1 after", 32'(gnt_cnt1), 32'd2);
    do_reset();
    chk("cnt0 cleared", 32'(gnt_cnt0), 32'd0);
    chk("cnt1 cleared", 32'(gnt_cnt1), 32'd0);
`endif

    // Randomized run over a 16-word window, seeded with known data by r0
    do_reset();
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 16'($urandom);
      do_txn(0, 1'b1, 14'(14'h0100 + i), model_mem[i], 16'h0, "rnd init");
    end
    last_win = 0;
    skip     = 0;
    cur      = 0;
    cur_rd   = '0;
    pend[0]  = 1'b0;
    pend[1]  = 1'b0;
    for (int r = 0; r < 2; r++) begin
      p_we[r] = 1'b0; p_idx[r] = 0; p_wd[r] = '0;
    end
    for (int cyc = 0; cyc < 900; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(0, 3) != 0)) begin
          pend[r]  = 1'b1;
          p_we[r]  = 1'($urandom_range(0, 1));
          p_idx[r] = int'($urandom_range(0, 15));
          p_wd[r]  = 16'($urandom);
        end
        drive(r, pend[r], p_we[r], 14'(14'h0100 + p_idx[r]), p_wd[r]);
      end
      tick();
      e_ack  = 32'd0;
      e_load = 1'b0;
      if (skip > 0) begin
        skip--;
        if (skip == 1) begin
          e_ack = (cur == 0) ? 32'd1 : 32'd2;
          if (!p_we[cur]) exp_rd[cur] = cur_rd;
          pend[cur] = 1'b0;
        end
      end else if (pend[0] || pend[1]) begin
        if (pend[0] && pend[1]) cur = (last_win == 0) ? 1 : 0;
        else cur = pend[0] ? 0 : 1;
        last_win = cur;
        skip     = 2;
        e_load   = p_we[cur];
        chk($sformatf("rnd %0d addr", cyc), 32'(ram_address), 32'(14'h0100 + p_idx[cur]));
        chk($sformatf("rnd %0d ram_in", cyc), 32'(ram_in), 32'(p_wd[cur]));
        cur_rd = model_mem[p_idx[cur]];
        if (p_we[cur]) model_mem[p_idx[cur]] = p_wd[cur];
      end
      chk($sformatf("rnd %0d ack", cyc), 32'({r1_ack, r0_ack}), e_ack);
      chk($sformatf("rnd %0d load", cyc), 32'(ram_load), 32'(e_load));
      chk_rdata($sformatf("rnd %0d", cyc));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
